sprite_pattern_ram: RTL and testbench

Parametrised sprite pattern store for the video subsystem. Supports 1, 2 or 4 bpp, a configurable sprite count and height, and a fixed sprite width of 16 pixels. The CPU reads and writes patterns as 32-bit words over a picosoc-style valid/ready port. The sprite engine requests one sprite row, with optional horizontal and vertical flip, and receives it as a 16-pixel stream at one pixel per clock. Storage is a single-port synchronous RAM arbitrated between the two sides.

---
 rtl/sprite_pattern_ram.sv | 206 ++++++++++++++++++++
 tb/tb_sprite_pattern_ram.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_pattern_ram.sv
// Sprite pattern store: one single-port RAM shared by a CPU word port and a row
// fetcher that streams 16 pixels (1/2/4 bpp) with optional horizontal/vertical flip.
module sprite_pattern_ram #(
  parameter int SPRITES  = 64,
  parameter int SPRITE_H = 16,
  parameter int BPP      = 1,
  localparam int AW = $clog2(SPRITES*SPRITE_H*BPP/2),
  localparam int SW = $clog2(SPRITES),
  localparam int RW = $clog2(SPRITE_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_valid,
  output logic          cpu_ready,
  input  logic [3:0]    cpu_wstrb,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  input  logic          fetch_valid,
  output logic          fetch_ready,
  input  logic [SW-1:0] fetch_sprite,
  input  logic [RW-1:0] fetch_row,
  input  logic          fetch_hflip,
  input  logic          fetch_vflip,
  output logic          pix_valid,
  output logic [BPP-1:0] pix_data,
  output logic          pix_last
);
  localparam int ROW_BITS = 16*BPP;
  localparam int DEPTH    = SPRITES*SPRITE_H*BPP/2;
  localparam int IW       = SW + RW;
  localparam int NWORDS   = (BPP == 4) ? 2 : 1;
  localparam logic [1:0] LOAD_LAST = 2'(NWORDS);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
  state_t state_reg, state_next;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         ram_q;
  logic [AW-1:0]       ram_addr;
  logic [AW-1:0]       base_addr;
  logic [AW-1:0]       ld_addr_reg;
  logic [RW-1:0]       row_eff;
  logic [IW-1:0]       row_idx;
  logic [1:0]          lcnt_reg;
  logic [3:0]          pcnt_reg;
  logic                hflip_reg;
  logic [ROW_BITS-1:0] row_reg;
  logic [ROW_BITS-1:0] full_row;
  logic [ROW_BITS-1:0] src_row;
  logic [BPP-1:0]      pix_arr [16];
  logic [3:0]          pix_k;
  logic [3:0]          pix_idx;
  logic [BPP-1:0]      pix_sel;
  logic                pix_valid_reg;
  logic                pix_last_reg;
  logic [BPP-1:0]      pix_data_reg;
  logic                load_rd;
  logic                cpu_busy, cpu_go, cpu_wr, cpu_rd;
  logic                rd_pend_reg;
  logic                cpu_ready_reg;
  logic [31:0]         cpu_rdata_reg;

  // Heights are powers of two, so SPRITE_H-1-row is just the bitwise inverse.
  assign row_eff = fetch_vflip ? ~fetch_row : fetch_row;
  assign row_idx = {fetch_sprite, row_eff};

  generate
    if (BPP == 1) begin : gen_row1
      logic half_reg;
      assign base_addr = row_idx[IW-1:1];
      always_ff @(posedge clk) begin
        if (reset)
          half_reg <= 1'b0;
        else if (state_reg == IDLE && fetch_valid)
          half_reg <= row_idx[0];
      end
      assign full_row = half_reg ? ram_q[31:16] : ram_q[15:0];
    end else if (BPP == 2) begin : gen_row2
      assign base_addr = row_idx;
      assign full_row  = ram_q;
    end else begin : gen_row4
      logic [31:0] lo_reg;
      assign base_addr = {row_idx, 1'b0};
      always_ff @(posedge clk) begin
        if (reset)
          lo_reg <= '0;
        else if (state_reg == LOAD && lcnt_reg == 2'd1)
          lo_reg <= ram_q;
      end
      assign full_row = {ram_q, lo_reg};
    end
  endgenerate

  // The first pixel leaves straight from the freshly assembled row; the rest come from row_reg.
  assign src_row = (state_reg == LOAD) ? full_row : row_reg;
  assign pix_k   = (state_reg == LOAD) ? 4'd0 : pcnt_reg;
  assign pix_idx = hflip_reg ? ~pix_k : pix_k;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : gen_pix
      assign pix_arr[gi] = src_row[gi*BPP +: BPP];
    end
  endgenerate
  assign pix_sel = pix_arr[pix_idx];

  // RAM port arbitration: fetch reads win, the CPU simply stays pending.
  assign load_rd  = (state_reg == LOAD) && (lcnt_reg < LOAD_LAST);
  assign cpu_busy = rd_pend_reg | cpu_ready_reg;
  assign cpu_go   = cpu_valid & ~cpu_busy & ~load_rd & ~reset;
  assign cpu_wr   = cpu_go & (|cpu_wstrb);
  assign cpu_rd   = cpu_go & ~(|cpu_wstrb);
  assign ram_addr = load_rd ? ld_addr_reg : cpu_addr;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (cpu_wr && cpu_wstrb[b])
        mem[ram_addr][b*8 +: 8] <= cpu_wdata[b*8 +: 8];
    end
    ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_reg   <= 1'b0;
      cpu_ready_reg <= 1'b0;
      cpu_rdata_reg <= '0;
    end else begin
      rd_pend_reg   <= cpu_rd;
      cpu_ready_reg <= cpu_wr | rd_pend_reg;
      cpu_rdata_reg <= rd_pend_reg ? ram_q : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fetch_valid) state_next = LOAD;
      LOAD:    if (lcnt_reg == LOAD_LAST) state_next = STREAM;
      STREAM:  if (pix_last_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lcnt_reg      <= '0;
      pcnt_reg      <= '0;
      hflip_reg     <= 1'b0;
      ld_addr_reg   <= '0;
      row_reg       <= '0;
      pix_valid_reg <= 1'b0;
      pix_last_reg  <= 1'b0;
      pix_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (fetch_valid) begin
            ld_addr_reg <= base_addr;
            hflip_reg   <= fetch_hflip;
            lcnt_reg    <= '0;
          end
        end
        LOAD: begin
          lcnt_reg <= lcnt_reg + 2'd1;
          if (load_rd)
            ld_addr_reg <= ld_addr_reg + AW'(1);
          if (lcnt_reg == LOAD_LAST) begin
            row_reg       <= full_row;
            pix_valid_reg <= 1'b1;
            pix_data_reg  <= pix_sel;
            pix_last_reg  <= 1'b0;
            pcnt_reg      <= 4'd1;
          end
        end
        STREAM: begin
          if (pix_last_reg) begin
            pix_valid_reg <= 1'b0;
            pix_last_reg  <= 1'b0;
            pix_data_reg  <= '0;
          end else begin
            pix_data_reg <= pix_sel;
            pix_last_reg <= (pcnt_reg == 4'd15);
            pcnt_reg     <= pcnt_reg + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fetch_ready = (state_reg == IDLE);
  assign pix_valid   = pix_valid_reg;
  assign pix_last    = pix_last_reg;
  assign pix_data    = pix_data_reg;
  assign cpu_ready   = cpu_ready_reg;
  assign cpu_rdata   = cpu_rdata_reg;

endmodule

// File: tb/tb_sprite_pattern_ram.sv
// Scoreboard bench: a 1 bpp and a 4 bpp instance, each checked against a bit-addressed
// memory model; monitors pop expected pixels / CPU replies independently of stimulus.
module tb_sprite_pattern_ram;
  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic          reset_s      [2];
  logic          cpu_valid    [2];
  logic          cpu_ready    [2];
  logic [3:0]    cpu_wstrb    [2];
  logic [AW-1:0] cpu_addr     [2];
  logic [31:0]   cpu_wdata    [2];
  logic [31:0]   cpu_rdata    [2];
  logic          fetch_valid  [2];
  logic          fetch_ready  [2];
  logic [3:0]    fetch_row    [2];
  logic          fetch_hflip  [2];
  logic          fetch_vflip  [2];
  logic          pix_valid    [2];
  logic          pix_last     [2];
  logic [2:0]    fs0;
  logic [0:0]    fs1;
  logic [0:0]    pd0;
  logic [3:0]    pd1;

  sprite_pattern_ram #(.SPRITES(8), .SPRITE_H(16), .BPP(1)) u_bpp1 (
    .clk(clk), .reset(reset_s[0]),
    .cpu_valid(cpu_valid[0]), .cpu_ready(cpu_ready[0]), .cpu_wstrb(cpu_wstrb[0]),
    .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]), .cpu_rdata(cpu_rdata[0]),
    .fetch_valid(fetch_valid[0]), .fetch_ready(fetch_ready[0]), .fetch_sprite(fs0),
    .fetch_row(fetch_row[0]), .fetch_hflip(fetch_hflip[0]), .fetch_vflip(fetch_vflip[0]),
    .pix_valid(pix_valid[0]), .pix_data(pd0), .pix_last(pix_last[0])
  );

  sprite_pattern_ram #(.SPRITES(2), .SPRITE_H(16), .BPP(4)) u_bpp4 (
    .clk(clk), .reset(reset_s[1]),
    .cpu_valid(cpu_valid[1]), .cpu_ready(cpu_ready[1]), .cpu_wstrb(cpu_wstrb[1]),
    .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]), .cpu_rdata(cpu_rdata[1]),
    .fetch_valid(fetch_valid[1]), .fetch_ready(fetch_ready[1]), .fetch_sprite(fs1),
    .fetch_row(fetch_row[1]), .fetch_hflip(fetch_hflip[1]), .fetch_vflip(fetch_vflip[1]),
    .pix_valid(pix_valid[1]), .pix_data(pd1), .pix_last(pix_last[1])
  );

  typedef struct packed {
    logic [3:0] v;
    logic       last;
    int         at;
  } pix_t;

  pix_t        pq0 [$];
  pix_t        pq1 [$];
  logic [32:0] cq0 [$];
  logic [32:0] cq1 [$];
  logic [31:0] mm [2][64];
  bit          last_seen [2];

  task automatic chk(input int d, input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s dut=%0d actual=%0h required=%0h t=%0t", name, d, act, req, $time);
    end
  endtask

  function automatic logic [3:0] get_pd(input int d);
    return (d == 0) ? {3'b000, pd0} : pd1;
  endfunction

  function automatic int pq_size(input int d);
    return (d == 0) ? pq0.size() : pq1.size();
  endfunction

  // Pixel p of a row sits at absolute bit (sprite*16+row)*16*bpp + p*bpp of a flat bit memory.
  function automatic logic [3:0] model_pix(input int d, input int sp, input int row, input int p);
    int bpp;
    int bitpos;
    logic [31:0] s;
    bpp = (d == 0) ? 1 : 4;
    bitpos = (sp*16 + row)*16*bpp + p*bpp;
    s = mm[d][bitpos/32] >> (bitpos % 32);
    return (bpp == 1) ? {3'b000, s[0]} : s[3:0];
  endfunction

  task automatic mon_pix(input int d);
    pix_t e;
    if (last_seen[d]) begin
      chk(d, fetch_ready[d] && !pix_valid[d], "ready_after_last",
          {62'd0, fetch_ready[d], pix_valid[d]}, 64'h2);
      last_seen[d] = 1'b0;
    end
    if (pix_valid[d]) begin
      if (pq_size(d) == 0) begin
        chk(d, 1'b0, "unexpected_pixel", 64'(get_pd(d)), 64'd0);
      end else begin
        e = (d == 0) ? pq0.pop_front() : pq1.pop_front();
        chk(d, get_pd(d) == e.v, "pix_data", 64'(get_pd(d)), 64'(e.v));
        chk(d, pix_last[d] == e.last, "pix_last", 64'(pix_last[d]), 64'(e.last));
        chk(d, cyc == e.at, "pix_cycle", 64'(cyc), 64'(e.at));
        if (e.last) last_seen[d] = 1'b1;
      end
    end else begin
      chk(d, get_pd(d) == 4'd0 && !pix_last[d], "idle_pix",
          {59'd0, pix_last[d], get_pd(d)}, 64'd0);
    end
  endtask

  task automatic mon_cpu(input int d);
    logic [32:0] e;
    if (cpu_ready[d]) begin
      if ((d == 0 ? cq0.size() : cq1.size()) == 0) begin
        chk(d, 1'b0, "unexpected_cpu_ready", 64'd1, 64'd0);
      end else begin
        e = (d == 0) ? cq0.pop_front() : cq1.pop_front();
        if (e[32]) chk(d, cpu_rdata[d] == e[31:0], "cpu_rdata", 64'(cpu_rdata[d]), 64'(e[31:0]));
      end
    end
  endtask

  always @(negedge clk) begin
    mon_pix(0);
    mon_pix(1);
    mon_cpu(0);
    mon_cpu(1);
  end

  // exp_lat = 0 means only the timeout bound is checked.
  task automatic cpu_op(input int d, input int a, input logic [31:0] wd,
                        input logic [3:0] st, input int exp_lat);
    int n;
    logic [31:0] w;
    cpu_addr[d]  = AW'(a);
    cpu_wdata[d] = wd;
    cpu_wstrb[d] = st;
    cpu_valid[d] = 1'b1;
    if (st == 4'd0) begin
      if (d == 0) cq0.push_back({1'b1, mm[d][a]}); else cq1.push_back({1'b1, mm[d][a]});
    end else begin
      w = mm[d][a];
      for (int b = 0; b < 4; b++) if (st[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      mm[d][a] = w;
      if (d == 0) cq0.push_back({1'b0, w}); else cq1.push_back({1'b0, w});
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ready[d] && n < 50);
    cpu_valid[d] = 1'b0;
    if (!cpu_ready[d]) chk(d, 1'b0, "cpu_timeout", 64'(n), 64'd50);
    else if (exp_lat > 0) chk(d, n == exp_lat, "cpu_latency", 64'(n), 64'(exp_lat));
    $display("cpu dut=%0d %s addr=%0d data=%08h strb=%h cycles=%0d",
             d, (st == 4'd0) ? "rd" : "wr", a, wd, st, n);
    @(negedge clk);
  endtask

  task automatic do_fetch(input int d, input int sp, input int row, input bit hf, input bit vf);
    int n;
    int e0;
    int reff;
    pix_t e;
    n = 0;
    while (!fetch_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!fetch_ready[d]) begin
      chk(d, 1'b0, "fetch_ready_timeout", 64'(n), 64'd100);
      return;
    end
    if (d == 0) fs0 = 3'(sp); else fs1 = 1'(sp);
    fetch_row[d]   = 4'(row);
    fetch_hflip[d] = hf;
    fetch_vflip[d] = vf;
    fetch_valid[d] = 1'b1;
    @(negedge clk);
    fetch_valid[d] = 1'b0;
    e0 = cyc;
    reff = vf ? 15 - row : row;
    for (int p = 0; p < 16; p++) begin
      e.v    = model_pix(d, sp, reff, hf ? 15 - p : p);
      e.last = (p == 15);
      e.at   = e0 + ((d == 0) ? 2 : 3) + p;
      if (d == 0) pq0.push_back(e); else pq1.push_back(e);
    end
    $display("fetch dut=%0d sprite=%0d row=%0d hflip=%0d vflip=%0d", d, sp, row, hf, vf);
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while ((pq_size(d) != 0 || !fetch_ready[d]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(d, pq_size(d) == 0 && fetch_ready[d], "stream_drain", 64'(pq_size(d)), 64'd0);
  endtask

  task automatic check_reset_outputs(input int d);
    chk(d, fetch_ready[d] == 1'b1, "rst_fetch_ready", 64'(fetch_ready[d]), 64'd1);
    chk(d, pix_valid[d] == 1'b0, "rst_pix_valid", 64'(pix_valid[d]), 64'd0);
    chk(d, pix_last[d] == 1'b0, "rst_pix_last", 64'(pix_last[d]), 64'd0);
    chk(d, get_pd(d) == 4'd0, "rst_pix_data", 64'(get_pd(d)), 64'd0);
    chk(d, cpu_ready[d] == 1'b0, "rst_cpu_ready", 64'(cpu_ready[d]), 64'd0);
    chk(d, cpu_rdata[d] == 32'd0, "rst_cpu_rdata", 64'(cpu_rdata[d]), 64'd0);
  endtask

  // Reset lands during the 5th pixel; the stream must simply vanish.
  task automatic reset_mid(input int d, input int sp, input int row);
    int n;
    n = 0;
    do_fetch(d, sp, row, 1'b0, 1'b1);
    while (pq_size(d) > 11 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(d, pq_size(d) == 11, "mid_reset_position", 64'(pq_size(d)), 64'd11);
    reset_s[d] = 1'b1;
    if (d == 0) pq0.delete(); else pq1.delete();
    @(negedge clk);
    chk(d, pix_valid[d] == 1'b0, "mid_reset_pix_valid", 64'(pix_valid[d]), 64'd0);
    chk(d, fetch_ready[d] == 1'b1, "mid_reset_fetch_ready", 64'(fetch_ready[d]), 64'd1);
    chk(d, pix_last[d] == 1'b0, "mid_reset_pix_last", 64'(pix_last[d]), 64'd0);
    reset_s[d] = 1'b0;
    $display("reset dut=%0d mid-stream", d);
    do_fetch(d, sp, row, 1'b0, 1'b1);
    wait_idle(d);
  endtask

  task automatic random_run(input int d, input int iters);
    int r;
    for (int i = 0; i < iters; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: cpu_op(d, $urandom_range(0, 63), $urandom, 4'($urandom_range(1, 15)), 0);
        1: cpu_op(d, $urandom_range(0, 63), 32'd0, 4'd0, 0);
        default: do_fetch(d, $urandom_range(0, (d == 0) ? 7 : 1), $urandom_range(0, 15),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      endcase
    end
    wait_idle(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset_s[d] = 1'b1;
      cpu_valid[d] = 1'b0;
      cpu_wstrb[d] = 4'd0;
      cpu_addr[d] = '0;
      cpu_wdata[d] = '0;
      fetch_valid[d] = 1'b0;
      fetch_row[d] = '0;
      fetch_hflip[d] = 1'b0;
      fetch_vflip[d] = 1'b0;
      last_seen[d] = 1'b0;
    end
    fs0 = '0;
    fs1 = '0;
    repeat (3) @(negedge clk);
    reset_s[0] = 1'b0;
    reset_s[1] = 1'b0;
    check_reset_outputs(0);
    check_reset_outputs(1);

    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 64; a++) cpu_op(d, a, $urandom, 4'hF, 1);

    // 1 bpp directed cases
    cpu_op(0, 0, 32'h0000A5C3, 4'hF, 1);
    do_fetch(0, 0, 0, 1'b0, 1'b0);
    wait_idle(0);
    do_fetch(0, 0, 1, 1'b1, 1'b0);
    wait_idle(0);
    cpu_op(0, 0, 32'h80000000, 4'hF, 1);
    do_fetch(0, 0, 1, 1'b1, 1'b0);
    wait_idle(0);
    cpu_op(0, 5, 32'h11223344, 4'hF, 1);
    cpu_op(0, 5, 32'hFFFFFFFF, 4'b0010, 1);
    cpu_op(0, 5, 32'd0, 4'd0, 2);
    do_fetch(0, 3, 7, 1'b0, 1'b0);
    cpu_op(0, 9, $urandom, 4'hF, 2);
    repeat (3) @(negedge clk);
    cpu_op(0, 9, 32'd0, 4'd0, 2);
    wait_idle(0);
    reset_mid(0, 2, 3);
    random_run(0, 40);

    // 4 bpp directed cases
    cpu_op(1, 2, 32'h76543210, 4'hF, 1);
    cpu_op(1, 3, 32'hFEDCBA98, 4'hF, 1);
    do_fetch(1, 0, 1, 1'b0, 1'b0);
    wait_idle(1);
    do_fetch(1, 0, 14, 1'b0, 1'b1);
    wait_idle(1);
    do_fetch(1, 1, 5, 1'b1, 1'b0);
    cpu_op(1, 20, $urandom, 4'hF, 3);
    repeat (2) @(negedge clk);
    cpu_op(1, 20, 32'd0, 4'd0, 2);
    wait_idle(1);
    reset_mid(1, 1, 6);
    random_run(1, 40);

    repeat (4) @(negedge clk);
    chk(0, cq0.size() == 0, "cpu_drain", 64'(cq0.size()), 64'd0);
    chk(1, cq1.size() == 0, "cpu_drain", 64'(cq1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
